// File: rtl/text_pkg.sv
// Shared types, default constants and sizing helper for the text sequencer.
package text_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefDepth     = 8;
    localparam int unsigned DefCols      = 40;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StHold  = 2'd2
    } state_e;

    // Ceiling log2, used to size FIFO pointers (value >= 2 in practice).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Character FIFO: storage, pointers, count, full/empty and sticky overflow.
module char_fifo
    import text_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow
);

    localparam int unsigned PtrW = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]       r_wr_ptr;
    logic [PtrW-1:0]       r_rd_ptr;
    logic [PtrW:0]         r_count;
    logic                  r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    // Fullness is judged on the pre-edge count, so a push while full is
    // dropped even if a pop happens on the same edge.
    assign w_full    = (r_count == (PtrW + 1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_push && !w_full && !i_flush;
    assign w_pop_ok  = i_pop && !w_empty && !i_flush;

    assign o_head     = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

    // Storage write; contents need no reset since the count guards reads.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer, count and overflow bookkeeping; flush clears everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PtrW + 1)'(1);
                2'b01:   r_count <= r_count - (PtrW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/text_sequencer.sv
// Timer-paced character sequencer: FIFO in, one start pulse per character,
// column tracking with end-of-line pulse.
module text_sequencer
    import text_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned COLS       = DefCols,
    parameter int unsigned COL_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  overflow,
    input  logic                  flush,
    output logic                  timer_start,
    input  logic                  timer_finish,
    output logic [DATA_WIDTH-1:0] char_code,
    output logic                  char_valid,
    output logic [COL_WIDTH-1:0]  col,
    output logic                  line_done
);

    state_e                r_state;
    logic [DATA_WIDTH-1:0] r_char_code;
    logic [COL_WIDTH-1:0]  r_col;
    logic                  r_line_done;

    state_e                w_state_next;
    logic [DATA_WIDTH-1:0] w_char_code_next;
    logic [COL_WIDTH-1:0]  w_col_next;
    logic                  w_line_done_next;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_fifo_head;
    logic                  w_fifo_empty;

    char_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_char_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (wr_en),
        .i_data     (wr_data),
        .i_pop      (w_pop),
        .i_flush    (flush),
        .o_head     (w_fifo_head),
        .o_full     (full),
        .o_empty    (w_fifo_empty),
        .o_overflow (overflow)
    );

    // Next-state, pop request, column advance and line-done pulse.
    always_comb begin
        w_state_next     = r_state;
        w_char_code_next = r_char_code;
        w_col_next       = r_col;
        w_line_done_next = 1'b0;
        w_pop            = 1'b0;
        if (flush) begin
            w_state_next = StIdle;
            w_col_next   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!w_fifo_empty) begin
                        w_pop            = 1'b1;
                        w_char_code_next = w_fifo_head;
                        w_state_next     = StIssue;
                    end
                end
                StIssue: begin
                    w_state_next = StHold;
                end
                StHold: begin
                    if (timer_finish) begin
                        if (r_col == COL_WIDTH'(COLS - 1)) begin
                            w_col_next       = '0;
                            w_line_done_next = 1'b1;
                        end else begin
                            w_col_next = r_col + COL_WIDTH'(1);
                        end
                        if (!w_fifo_empty) begin
                            w_pop            = 1'b1;
                            w_char_code_next = w_fifo_head;
                            w_state_next     = StIssue;
                        end else begin
                            w_state_next = StIdle;
                        end
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_char_code <= '0;
            r_col       <= '0;
            r_line_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_char_code <= w_char_code_next;
            r_col       <= w_col_next;
            r_line_done <= w_line_done_next;
        end
    end

    assign timer_start = (r_state == StIssue);
    assign char_valid  = (r_state != StIdle);
    assign char_code   = r_char_code;
    assign col         = r_col;
    assign line_done   = r_line_done;

endmodule
